// File: rtl/precinct_ballot_arbiter.sv
// Precinct ballot arbiter: opens/closes the poll, round-robin arbitrates
// citizen voters onto a single board-of-elections port through a one-entry
// valid/ready output register, and counts delivered ballots.
module precinct_ballot_arbiter #(
    parameter int unsigned NUM_VOTERS = 4,
    parameter int unsigned VOTE_W     = 2,
    parameter int unsigned COUNT_W    = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             io_open,
    input  logic                             io_close,
    input  logic [NUM_VOTERS-1:0]            io_req,
    input  logic [NUM_VOTERS*VOTE_W-1:0]     io_vote,
    output logic [NUM_VOTERS-1:0]            io_grant,
    output logic                             io_board_valid,
    input  logic                             io_board_ready,
    output logic [VOTE_W-1:0]                io_board_vote,
    output logic [$clog2(NUM_VOTERS)-1:0]    io_board_voter,
    output logic [NUM_VOTERS-1:0]            io_voted,
    output logic [COUNT_W-1:0]               io_total,
    output logic [1:0]                       io_state,
    output logic                             io_done
);

    localparam int unsigned VOTER_W = $clog2(NUM_VOTERS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPEN    = 2'd1,
        ST_CLOSING = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               state;
    logic                 done;
    logic [NUM_VOTERS-1:0] grant;
    logic                 board_valid;
    logic [VOTE_W-1:0]    board_vote;
    logic [VOTER_W-1:0]   board_voter;
    logic [NUM_VOTERS-1:0] voted;
    logic [COUNT_W-1:0]   total;
    logic [VOTER_W-1:0]   rr_ptr;

    logic [VOTE_W-1:0]    votes [NUM_VOTERS];
    logic [NUM_VOTERS-1:0] eligible;
    logic                 handshake;
    logic                 slot_free;
    logic                 found;
    logic [VOTER_W-1:0]   win_idx;
    logic [VOTE_W-1:0]    win_vote;
    logic [VOTER_W-1:0]   rr_next;
    logic                 capture;

    assign eligible  = io_req & ~voted;
    assign handshake = board_valid & io_board_ready;
    assign slot_free = ~board_valid | io_board_ready;
    assign capture   = (state == ST_OPEN) && slot_free && found;

    // Unpack the flat ballot bus into one entry per voter.
    always_comb begin
        for (int unsigned i = 0; i < NUM_VOTERS; i++) begin
            votes[i] = io_vote[i*VOTE_W +: VOTE_W];
        end
    end

    // Round-robin search: first eligible voter at or above rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        logic [VOTER_W-1:0] sel;
        idx      = 0;
        sel      = '0;
        found    = 1'b0;
        win_idx  = '0;
        win_vote = '0;
        for (int unsigned k = 0; k < NUM_VOTERS; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_VOTERS) begin
                idx = idx - NUM_VOTERS;
            end
            sel = VOTER_W'(idx);
            if (!found && eligible[sel]) begin
                found    = 1'b1;
                win_idx  = sel;
                win_vote = votes[sel];
            end
        end
    end

    // Pointer moves one past the winner so it becomes lowest priority next.
    always_comb begin
        if (32'(win_idx) == NUM_VOTERS - 1) begin
            rr_next = '0;
        end else begin
            rr_next = win_idx + 1'b1;
        end
    end

    // Poll FSM, capture register, voted mask and delivered-ballot counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            done        <= 1'b0;
            grant       <= '0;
            board_valid <= 1'b0;
            board_vote  <= '0;
            board_voter <= '0;
            voted       <= '0;
            total       <= '0;
            rr_ptr      <= '0;
        end else begin
            grant <= '0;

            if (handshake) begin
                board_valid <= 1'b0;
                if (total != '1) begin
                    total <= total + 1'b1;
                end
            end

            // A capture overrides the handshake clear so the slot refills
            // in the same cycle it drains.
            if (capture) begin
                board_valid    <= 1'b1;
                board_vote     <= win_vote;
                board_voter    <= win_idx;
                grant[win_idx] <= 1'b1;
                voted[win_idx] <= 1'b1;
                rr_ptr         <= rr_next;
            end

            case (state)
                ST_IDLE: begin
                    if (io_open) begin
                        state  <= ST_OPEN;
                        voted  <= '0;
                        total  <= '0;
                        rr_ptr <= '0;
                    end
                end
                ST_OPEN: begin
                    if (io_close || (&voted)) begin
                        state <= ST_CLOSING;
                    end
                end
                ST_CLOSING: begin
                    if (!board_valid || handshake) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (io_open) begin
                        state  <= ST_OPEN;
                        done   <= 1'b0;
                        voted  <= '0;
                        total  <= '0;
                        rr_ptr <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_grant       = grant;
    assign io_board_valid = board_valid;
    assign io_board_vote  = board_vote;
    assign io_board_voter = board_voter;
    assign io_voted       = voted;
    assign io_total       = total;
    assign io_state       = state;
    assign io_done        = done;

endmodule

// File: tb/tb_precinct_ballot_arbiter.sv
// Bench for precinct_ballot_arbiter: scenario tasks with inline checks and a
// ballot scoreboard popped whenever the BOE handshake fires.
module tb_precinct_ballot_arbiter;

    typedef struct packed {
        logic [1:0] voter;
        logic [1:0] vote;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_open;
    logic       io_close;
    logic [3:0] io_req;
    logic [7:0] io_vote;
    logic [3:0] io_grant;
    logic       io_board_valid;
    logic       io_board_ready;
    logic [1:0] io_board_vote;
    logic [1:0] io_board_voter;
    logic [3:0] io_voted;
    logic [7:0] io_total;
    logic [1:0] io_state;
    logic       io_done;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    precinct_ballot_arbiter #(
        .NUM_VOTERS(4),
        .VOTE_W    (2),
        .COUNT_W   (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_open       (io_open),
        .io_close      (io_close),
        .io_req        (io_req),
        .io_vote       (io_vote),
        .io_grant      (io_grant),
        .io_board_valid(io_board_valid),
        .io_board_ready(io_board_ready),
        .io_board_vote (io_board_vote),
        .io_board_voter(io_board_voter),
        .io_voted      (io_voted),
        .io_total      (io_total),
        .io_state      (io_state),
        .io_done       (io_done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    function automatic exp_t mk(input logic [1:0] voter, input logic [1:0] vote);
        exp_t e;
        e.voter = voter;
        e.vote  = vote;
        return e;
    endfunction

    // One clock: on the negedge before the edge, score any handshake about to
    // complete; then return 1 time unit after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clock);
        if (!reset && io_board_valid && io_board_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got voter=%0d vote=%b, expected no ballot", io_board_voter, io_board_vote);
            end else begin
                e = sb_q.pop_front();
                if (io_board_voter !== e.voter || io_board_vote !== e.vote) begin
                    n_err++;
                    $display("FAIL sb_ballot: got voter=%0d vote=%b, expected voter=%0d vote=%b",
                             io_board_voter, io_board_vote, e.voter, e.vote);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done();
        int k = 0;
        while (io_done !== 1'b1 && k < 8) begin
            step();
            k++;
        end
        n_cmp++;
        if (io_done !== 1'b1 || io_state !== 2'd3) begin
            n_err++;
            $display("FAIL wait_done: got done=%b state=%0d, expected done=1 state=3", io_done, io_state);
        end
    endtask

    task automatic go_open();
        io_open = 1'b1;
        step();
        io_open = 1'b0;
        n_cmp++;
        if (io_state !== 2'd1 || io_voted !== 4'b0000 || io_total !== 8'd0) begin
            n_err++;
            $display("FAIL open: got state=%0d voted=%b total=%0d, expected state=1 voted=0000 total=0",
                     io_state, io_voted, io_total);
        end
    endtask

    task automatic go_close();
        io_close = 1'b1;
        step();
        io_close = 1'b0;
        wait_done();
    endtask

    task automatic test_reset();
        reset = 1'b1; io_open = 1'b0; io_close = 1'b0; io_req = '0;
        io_vote = '0; io_board_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        n_cmp++;
        if ({io_grant, io_board_valid, io_board_vote, io_board_voter, io_voted, io_total, io_state, io_done} !== 24'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, expected 000000",
                     {io_grant, io_board_valid, io_board_vote, io_board_voter, io_voted, io_total, io_state, io_done});
        end
        io_req = 4'b1111;
        io_board_ready = 1'b1;
        step();
        step();
        n_cmp++;
        if (io_grant !== 4'b0000 || io_board_valid !== 1'b0 || io_state !== 2'd0) begin
            n_err++;
            $display("FAIL idle_no_capture: got grant=%b valid=%b state=%0d, expected 0000 0 0",
                     io_grant, io_board_valid, io_state);
        end
        io_req = '0;
    endtask

    task automatic test_single();
        go_open();
        io_req = 4'b0001;
        io_vote = 8'b00_00_00_10;
        io_board_ready = 1'b1;
        sb_q.push_back(mk(2'd0, 2'b10));
        step();
        n_cmp++;
        if (io_grant !== 4'b0001 || io_board_valid !== 1'b1 || io_board_vote !== 2'b10 ||
            io_board_voter !== 2'd0 || io_voted !== 4'b0001) begin
            n_err++;
            $display("FAIL single_capture: got grant=%b valid=%b vote=%b voter=%0d voted=%b, expected 0001 1 10 0 0001",
                     io_grant, io_board_valid, io_board_vote, io_board_voter, io_voted);
        end
        io_req = '0;
        step();
        n_cmp++;
        if (io_board_valid !== 1'b0 || io_total !== 8'd1 || io_grant !== 4'b0000) begin
            n_err++;
            $display("FAIL single_drain: got valid=%b total=%0d grant=%b, expected 0 1 0000",
                     io_board_valid, io_total, io_grant);
        end
        go_close();
        n_cmp++;
        if (io_total !== 8'd1 || io_voted !== 4'b0001) begin
            n_err++;
            $display("FAIL single_done_hold: got total=%0d voted=%b, expected 1 0001", io_total, io_voted);
        end
    endtask

    task automatic test_back_to_back();
        go_open();
        io_req = 4'b1111;
        io_vote = {2'b01, 2'b11, 2'b00, 2'b10};
        io_board_ready = 1'b1;
        sb_q.push_back(mk(2'd0, 2'b10));
        sb_q.push_back(mk(2'd1, 2'b00));
        sb_q.push_back(mk(2'd2, 2'b11));
        sb_q.push_back(mk(2'd3, 2'b01));
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (io_grant !== (4'b0001 << i) || io_board_valid !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_grant%0d: got grant=%b valid=%b, expected %b 1",
                         i, io_grant, io_board_valid, 4'b0001 << i);
            end
        end
        io_req = '0;
        wait_done();
        n_cmp++;
        if (io_total !== 8'd4 || io_voted !== 4'b1111) begin
            n_err++;
            $display("FAIL b2b_totals: got total=%0d voted=%b, expected 4 1111", io_total, io_voted);
        end
    endtask

    task automatic test_backpressure();
        go_open();
        io_board_ready = 1'b0;
        io_req = 4'b0011;
        io_vote = 8'b00_00_11_01;
        sb_q.push_back(mk(2'd0, 2'b01));
        step();
        n_cmp++;
        if (io_grant !== 4'b0001 || io_board_valid !== 1'b1 || io_board_voter !== 2'd0 || io_board_vote !== 2'b01) begin
            n_err++;
            $display("FAIL bp_first: got grant=%b valid=%b voter=%0d vote=%b, expected 0001 1 0 01",
                     io_grant, io_board_valid, io_board_voter, io_board_vote);
        end
        io_req = 4'b0010;
        io_vote = 8'b00_00_11_00;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (io_grant !== 4'b0000 || io_board_valid !== 1'b1 || io_board_voter !== 2'd0 || io_board_vote !== 2'b01) begin
                n_err++;
                $display("FAIL bp_hold%0d: got grant=%b valid=%b voter=%0d vote=%b, expected 0000 1 0 01",
                         i, io_grant, io_board_valid, io_board_voter, io_board_vote);
            end
        end
        sb_q.push_back(mk(2'd1, 2'b11));
        io_board_ready = 1'b1;
        step();
        n_cmp++;
        if (io_grant !== 4'b0010 || io_board_voter !== 2'd1 || io_board_vote !== 2'b11 || io_total !== 8'd1) begin
            n_err++;
            $display("FAIL bp_refill: got grant=%b voter=%0d vote=%b total=%0d, expected 0010 1 11 1",
                     io_grant, io_board_voter, io_board_vote, io_total);
        end
        io_req = '0;
        step();
        n_cmp++;
        if (io_total !== 8'd2 || io_board_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain: got total=%0d valid=%b, expected 2 0", io_total, io_board_valid);
        end
        go_close();
    endtask

    task automatic test_no_revote();
        go_open();
        io_req = 4'b0100;
        io_vote = 8'b00_10_00_00;
        io_board_ready = 1'b1;
        sb_q.push_back(mk(2'd2, 2'b10));
        step();
        n_cmp++;
        if (io_grant !== 4'b0100) begin
            n_err++;
            $display("FAIL revote_first: got grant=%b, expected 0100", io_grant);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (io_grant !== 4'b0000) begin
                n_err++;
                $display("FAIL revote_regrant%0d: got grant=%b, expected 0000", i, io_grant);
            end
        end
        n_cmp++;
        if (io_total !== 8'd1 || io_voted !== 4'b0100 || io_board_valid !== 1'b0) begin
            n_err++;
            $display("FAIL revote_total: got total=%0d voted=%b valid=%b, expected 1 0100 0",
                     io_total, io_voted, io_board_valid);
        end
        io_req = '0;
        go_close();
    endtask

    task automatic test_close_pending();
        go_open();
        io_board_ready = 1'b0;
        io_req = 4'b0001;
        io_vote = 8'b00_00_00_11;
        sb_q.push_back(mk(2'd0, 2'b11));
        step();
        n_cmp++;
        if (io_grant !== 4'b0001 || io_board_valid !== 1'b1) begin
            n_err++;
            $display("FAIL cp_capture: got grant=%b valid=%b, expected 0001 1", io_grant, io_board_valid);
        end
        io_req = 4'b0010;
        io_close = 1'b1;
        step();
        io_close = 1'b0;
        n_cmp++;
        if (io_state !== 2'd2 || io_grant !== 4'b0000 || io_board_valid !== 1'b1) begin
            n_err++;
            $display("FAIL cp_closing: got state=%0d grant=%b valid=%b, expected 2 0000 1",
                     io_state, io_grant, io_board_valid);
        end
        step();
        n_cmp++;
        if (io_state !== 2'd2 || io_grant !== 4'b0000 || io_total !== 8'd0) begin
            n_err++;
            $display("FAIL cp_stall: got state=%0d grant=%b total=%0d, expected 2 0000 0",
                     io_state, io_grant, io_total);
        end
        io_board_ready = 1'b1;
        step();
        n_cmp++;
        if (io_total !== 8'd1 || io_state !== 2'd3 || io_done !== 1'b1 ||
            io_board_valid !== 1'b0 || io_voted !== 4'b0001) begin
            n_err++;
            $display("FAIL cp_done: got total=%0d state=%0d done=%b valid=%b voted=%b, expected 1 3 1 0 0001",
                     io_total, io_state, io_done, io_board_valid, io_voted);
        end
        io_req = '0;
    endtask

    task automatic test_reset_mid();
        go_open();
        io_board_ready = 1'b0;
        io_req = 4'b0100;
        io_vote = 8'b00_01_00_00;
        sb_q.push_back(mk(2'd2, 2'b01));
        step();
        n_cmp++;
        if (io_board_valid !== 1'b1 || io_board_voter !== 2'd2) begin
            n_err++;
            $display("FAIL rm_pending: got valid=%b voter=%0d, expected 1 2", io_board_valid, io_board_voter);
        end
        reset = 1'b1;
        io_req = '0;
        sb_q.delete();
        step();
        reset = 1'b0;
        n_cmp++;
        if ({io_grant, io_board_valid, io_board_vote, io_board_voter, io_voted, io_total, io_state, io_done} !== 24'd0) begin
            n_err++;
            $display("FAIL rm_reset_outputs: got %h, expected 000000",
                     {io_grant, io_board_valid, io_board_vote, io_board_voter, io_voted, io_total, io_state, io_done});
        end
        go_open();
        io_req = 4'b1010;
        io_vote = 8'b10_00_01_00;
        io_board_ready = 1'b1;
        sb_q.push_back(mk(2'd1, 2'b01));
        sb_q.push_back(mk(2'd3, 2'b10));
        step();
        n_cmp++;
        if (io_grant !== 4'b0010 || io_board_voter !== 2'd1) begin
            n_err++;
            $display("FAIL rm_rr_restart: got grant=%b voter=%0d, expected 0010 1", io_grant, io_board_voter);
        end
        io_req = 4'b1000;
        step();
        n_cmp++;
        if (io_grant !== 4'b1000 || io_board_voter !== 2'd3) begin
            n_err++;
            $display("FAIL rm_second: got grant=%b voter=%0d, expected 1000 3", io_grant, io_board_voter);
        end
        io_req = '0;
        step();
        n_cmp++;
        if (io_total !== 8'd2 || io_board_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rm_total: got total=%0d valid=%b, expected 2 0", io_total, io_board_valid);
        end
        go_close();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_no_revote();
        test_close_pending();
        test_reset_mid();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d undelivered ballots, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/precinct_ballot_arbiter.md
Name: precinct_ballot_arbiter

Overview:
Controller sitting between a precinct's citizen voters and its board-of-elections (BOE) tally input. It opens and closes the poll and round-robin arbitrates the single BOE port among NUM_VOTERS requesters. Each voter gets exactly one accepted ballot per election. Ballots are forwarded through a one-entry output register with a valid/ready handshake, and completed ballots are counted.

Parameters:
NUM_VOTERS, 4, number of citizen requesters (>=2)
VOTE_W, 2, ballot width in bits
COUNT_W, 8, width of the accepted-ballot counter

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
io_open  in  1  pulse: start election (accepted in IDLE or DONE)
io_close  in  1  pulse: end election (accepted in OPEN)
io_req  in  NUM_VOTERS  per-voter request, level, held until grant
io_vote  in  NUM_VOTERS*VOTE_W  ballots, voter i at bits [i*VOTE_W +: VOTE_W]
io_grant  out  NUM_VOTERS  one-hot pulse: ballot captured
io_board_valid  out  1  ballot register holds a ballot for BOE
io_board_ready  in  1  BOE accepts the ballot this cycle
io_board_vote  out  VOTE_W  ballot to BOE
io_board_voter  out  clog2(NUM_VOTERS)  index of the ballot's voter
io_voted  out  NUM_VOTERS  voters whose ballot has been captured
io_total  out  COUNT_W  ballots delivered to BOE (valid && ready)
io_state  out  2  0 IDLE, 1 OPEN, 2 CLOSING, 3 DONE
io_done  out  1  high in DONE

Behaviour:
- Reset: state IDLE. grant=0, board_valid=0, board_vote=0, board_voter=0, voted=0, total=0, RR pointer=0, done=0.
- IDLE: io_open -> OPEN next cycle. No captures.
- OPEN: the eligible set is io_req & ~voted.
- A capture slot is free when board_valid==0, or when board_valid && io_board_ready.
- If the slot is free and the eligible set is non-empty, the winner is the first eligible index searched upward from the RR pointer, with wrap-around.
- On capture at edge T: at T+1 board_valid=1, board_vote=winner's ballot, board_voter=winner, grant[winner]=1 for exactly one cycle, voted[winner]=1, RR pointer=(winner+1) mod NUM_VOTERS.
- Latency is one cycle from request to grant/valid. Back-to-back captures are allowed when BOE holds ready high, giving 1 ballot per cycle.
- board_vote and board_voter are held stable while valid && !ready.
- A voter with voted==1 is never granted again. Its req is ignored and it must deassert req itself.
- io_total increments on every valid && ready cycle and saturates at all-ones.
- Auto-close: when voted becomes all ones, OPEN -> CLOSING in the following cycle.
- io_close in OPEN -> CLOSING. A capture decided in the same cycle as io_close still happens. io_open in OPEN is ignored.
- CLOSING: no new captures, grant=0. When board_valid==0, or when a handshake completes this cycle, go to DONE next cycle.
- DONE: done=1, voted and total hold. io_open -> OPEN next cycle, clearing voted and total and resetting the RR pointer to 0. io_close is ignored.
- Reset mid-operation: any pending ballot is discarded (board_valid=0) and is not counted.

Test Plan:
- Reset, open, req=4'b0001 with vote0=2'b10, ready=1 -> grant=0001 and board_valid=1, board_vote=10, board_voter=0 one cycle after the capture edge; next cycle valid=0, total=1.
- Open, req=4'b1111 held, ready=1 -> grants 0001,0010,0100,1000 on consecutive cycles; voted=1111; auto-close reaches CLOSING then DONE; total=4.
- Open, req=4'b0011, ready=0 for 5 cycles -> only voter 0 is granted; board_vote/voter stay stable; voter 1 is granted in the cycle after ready rises.
- After voter 2 votes, keep req[2]=1 with the others idle -> no further grant[2]; total stays 1.
- Pending ballot with ready=0, pulse io_close -> state CLOSING, no grants; assert ready -> total increments and the state moves to DONE the cycle after.
- Assert reset while board_valid=1 in OPEN -> next cycle all outputs at reset values and total=0. A later open/vote sequence behaves as after a fresh reset.
